tty_arbiter: RTL and testbench

TTY_ARBITER -- requirements
Module: tty_arbiter

---
 rtl/tty_arbiter.sv | 151 +++++++++++++++
 tb/tb_tty_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tty_arbiter.sv
// Two-requester round-robin character arbiter feeding a tty.
// Accepted characters are queued in a small FIFO. A three-state drain FSM
// pops one character, strobes it for one cycle, and then idles for GAP cycles.
module tty_arbiter #(
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         req0_valid,
    input  logic [7:0]                   req0_data,
    output logic                         req0_ready,
    input  logic                         req1_valid,
    input  logic [7:0]                   req1_data,
    output logic                         req1_ready,
    output logic [7:0]                   tty_data,
    output logic                         tty_enabled,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [GW-1:0] gap_cnt;
    logic          prio;
    logic          grant0;
    logic          grant1;
    logic          full;
    logic          push;
    logic          pop;
    logic [7:0]    push_data;

    assign full       = (count == CW'(DEPTH));
    assign req0_ready = grant0 && !full;
    assign req1_ready = grant1 && !full;
    assign push       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign push_data  = grant1 ? req1_data : req0_data;
    assign pop        = (state == S_IDLE) && (count != '0);

    // Grant: a lone valid requester wins; on contention, prio names the winner
    always_comb begin
        grant0 = req0_valid && (!req1_valid || !prio);
        grant1 = req1_valid && (!req0_valid || prio);
    end

    // Round-robin pointer: after serving req0, favour req1 next time, and vice versa
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio <= 1'b0;
        end else if (push) begin
            prio <= grant0;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leave count unchanged
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; no reset is needed because count guards every read
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // Output character register, loaded on each pop and held until the next one
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tty_data <= 8'h00;
        end else if (pop) begin
            tty_data <= fifo_mem[rd_ptr];
        end
    end

    // Drain FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Drain FSM next state: IDLE pops, SEND lasts one cycle, GAP runs out its counter
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                state_next = (GAP > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Gap down-counter: loaded during SEND so that GAP lasts exactly GAP cycles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt <= '0;
        end else if (state == S_SEND) begin
            gap_cnt <= GW'((GAP > 0) ? (GAP - 1) : 0);
        end else if ((state == S_GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end

    assign tty_enabled = (state == S_SEND);
    assign busy        = (count != '0) || (state != S_IDLE);

endmodule

// File: tb/tb_tty_arbiter.sv
// Scoreboard testbench for tty_arbiter: the stimulus queues the expected
// characters and a monitor checks every tty strobe against that queue.
module tb_tty_arbiter;

    logic       clock;
    logic       reset_n;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic [7:0] tty_data;
    logic       tty_enabled;
    logic       busy;
    logic [2:0] count;

    logic       g0_valid;
    logic [7:0] g0_data;
    logic       g0_ready;
    logic       g0_r1_ready;
    logic [7:0] g0_tty_data;
    logic       g0_tty_enabled;
    logic       g0_busy;
    logic [2:0] g0_count;

    int         cyc;
    int         n_checks;
    int         n_fail;
    logic [7:0] exp_q [$];
    int         strobe_q [$];

    tty_arbiter #(.DEPTH(4), .GAP(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .tty_data    (tty_data),
        .tty_enabled (tty_enabled),
        .busy        (busy),
        .count       (count)
    );

    tty_arbiter #(.DEPTH(4), .GAP(0)) dut_g0 (
        .clock       (clock),
        .reset_n     (reset_n),
        .req0_valid  (g0_valid),
        .req0_data   (g0_data),
        .req0_ready  (g0_ready),
        .req1_valid  (1'b0),
        .req1_data   (8'h00),
        .req1_ready  (g0_r1_ready),
        .tty_data    (g0_tty_data),
        .tty_enabled (g0_tty_enabled),
        .busy        (g0_busy),
        .count       (g0_count)
    );

    // 10-time-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Free-running cycle index, stepped at every rising edge
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic logic ready_of(input int r);
        return (r == 0) ? req0_ready : req1_ready;
    endfunction

    // Offer one character on requester r and return the cycle index of its acceptance
    task automatic apply_stimulus(input int r, input logic [7:0] d, output int acc);
        int n;
        n = 0;
        acc = -1;
        @(negedge clock);
        if (r == 0) begin
            req0_valid = 1'b1;
            req0_data  = d;
        end else begin
            req1_valid = 1'b1;
            req1_data  = d;
        end
        #1;
        while (!ready_of(r) && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (n >= 100) begin
            report_timeout("accept");
        end else begin
            @(posedge clock);
            #1;
            acc = cyc;
        end
        if (r == 0) begin
            req0_valid = 1'b0;
        end else begin
            req1_valid = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) report_timeout("drain");
        check_output("all_printed", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
        strobe_q.delete();
    endtask

    // Monitor: every strobe must match the oldest expected character
    always @(negedge clock) begin
        if (reset_n && tty_enabled) begin
            strobe_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_strobe: tty_data=%0d with no character expected", tty_data);
            end else begin
                check_output("tty_data", int'(tty_data), int'(exp_q.pop_front()));
            end
        end
    end

    // Watchdog so the bench always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int         k;
        int         k0;
        int         acc [6];
        logic [7:0] str [6];

        str = '{8'd49, 8'd50, 8'd51, 8'd52, 8'd53, 8'd10};
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        g0_valid   = 1'b0;
        g0_data    = 8'h00;

        #12;
        check_output("reset_tty_enabled", int'(tty_enabled), 0);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_count", int'(count), 0);
        check_output("reset_tty_data", int'(tty_data), 0);
        do_reset();

        // Single character: strobe one cycle after acceptance, idle after the gap
        exp_q.push_back(8'd49);
        apply_stimulus(0, 8'd49, k);
        wait_cyc(k + 3);
        check_output("single_strobes", strobe_q.size(), 1);
        if (strobe_q.size() > 0) check_output("single_latency", strobe_q[0] - k, 1);
        check_output("single_busy_in_gap", int'(busy), 1);
        check_output("single_enabled_in_gap", int'(tty_enabled), 0);
        check_output("single_data_held", int'(tty_data), 49);
        wait_cyc(k + 4);
        check_output("single_busy_done", int'(busy), 0);
        wait_cyc(k + 12);
        check_output("single_one_pulse", strobe_q.size(), 1);

        // Contention from reset: req0 favoured first, then alternate
        do_reset();
        exp_q.push_back("A");
        exp_q.push_back("a");
        exp_q.push_back("B");
        exp_q.push_back("b");
        fork
            begin
                int a0;
                apply_stimulus(0, "A", a0);
                apply_stimulus(0, "B", a0);
            end
            begin
                int a1;
                apply_stimulus(1, "a", a1);
                apply_stimulus(1, "b", a1);
            end
        join
        wait_drain(200);

        // Full FIFO: the sixth push stalls until the drain frees a slot
        strobe_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(8'h60 + i));
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 8'(8'h60 + i), acc[i]);
            if (i == 4) check_output("full_count", int'(count), 4);
        end
        check_output("full_fifth_accept", acc[4] - acc[0], 4);
        check_output("full_stalled_accept", acc[5] - acc[0], 6);
        wait_drain(200);
        check_output("full_strobes", strobe_q.size(), 6);
        if (strobe_q.size() == 6) begin
            check_output("full_first_latency", strobe_q[0] - acc[0], 1);
            for (int i = 1; i < 6; i++) check_output("gap2_period", strobe_q[i] - strobe_q[i-1], 4);
        end

        // String through req1, one strobe every GAP+2 cycles
        strobe_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(str[i]);
        for (int i = 0; i < 6; i++) apply_stimulus(1, str[i], acc[i]);
        wait_drain(200);
        check_output("string_strobes", strobe_q.size(), 6);
        if (strobe_q.size() == 6) begin
            for (int i = 1; i < 6; i++) check_output("string_period", strobe_q[i] - strobe_q[i-1], 4);
        end

        // GAP=0 with the FIFO kept fed: strobe on every second cycle
        @(negedge clock);
        g0_valid = 1'b1;
        g0_data  = 8'h55;
        k0 = cyc + 1;
        for (int i = 1; i <= 20; i++) begin
            wait_cyc(k0 + i);
            check_output("gap0_strobe", int'(g0_tty_enabled), i % 2);
            if ((i % 2) == 1) check_output("gap0_data", int'(g0_tty_data), 8'h55);
        end
        g0_valid = 1'b0;

        // Reset during the second SEND with three characters still buffered
        strobe_q.delete();
        exp_q.push_back(8'h70);
        exp_q.push_back(8'h71);
        for (int i = 0; i < 5; i++) apply_stimulus(0, 8'(8'h70 + i), acc[i]);
        wait_cyc(acc[0] + 5);
        check_output("pre_reset_enabled", int'(tty_enabled), 1);
        check_output("pre_reset_count", int'(count), 3);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("async_enabled", int'(tty_enabled), 0);
        check_output("async_count", int'(count), 0);
        check_output("async_busy", int'(busy), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        check_output("post_reset_strobes", strobe_q.size(), 2);
        check_output("post_reset_busy", int'(busy), 0);
        check_output("post_reset_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
